// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and address-field helpers for the direct-mapped icache
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int BYTE_OFF_W = 2;

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int line_words, input int num_lines);
    return 32 - BYTE_OFF_W - $clog2(line_words) - $clog2(num_lines);
  endfunction

  // Field extractors return full-width values; callers size-cast to the field width.
  function automatic logic [31:0] addr_word(input logic [31:0] a, input int line_words);
    return (a >> BYTE_OFF_W) & 32'(line_words - 1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int line_words,
                                             input int num_lines);
    return (a >> (BYTE_OFF_W + $clog2(line_words))) & 32'(num_lines - 1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int line_words,
                                           input int num_lines);
    return a >> (BYTE_OFF_W + $clog2(line_words) + $clog2(num_lines));
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a, input int line_words);
    return a & ~32'(line_words * 4 - 1);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// rtl/icache_data_ram.sv - instruction data store, synchronous write, asynchronous read
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Fill writes land one word per accepted memory beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with line fill FSM
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rd,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_waitrequest,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_waitrequest,
  input  logic        flush,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
);

  localparam int WORD_W  = word_w(LINE_WORDS);
  localparam int INDEX_W = index_w(NUM_LINES);
  localparam int TAG_W   = tag_w(LINE_WORDS, NUM_LINES);

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [31:0]          base_q, base_d;
  logic                 flush_pending_q, flush_pending_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic [31:0]          hits_q, hits_d;
  logic [31:0]          misses_q, misses_d;

  logic [WORD_W-1:0]  cpu_word;
  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               ram_we;
  logic [31:0]        ram_rdata;

  assign cpu_word   = WORD_W'(addr_word(cpu_addr, LINE_WORDS));
  assign cpu_index  = INDEX_W'(addr_index(cpu_addr, LINE_WORDS, NUM_LINES));
  assign cpu_tag    = TAG_W'(addr_tag(cpu_addr, LINE_WORDS, NUM_LINES));
  assign fill_index = INDEX_W'(addr_index(base_q, LINE_WORDS, NUM_LINES));
  assign fill_tag   = TAG_W'(addr_tag(base_q, LINE_WORDS, NUM_LINES));
  assign hit        = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  icache_data_ram #(
    .DEPTH(NUM_LINES * LINE_WORDS),
    .AW   (INDEX_W + WORD_W)
  ) u_data_ram (
    .clk  (clock),
    .we   (ram_we),
    .waddr({fill_index, fill_cnt_q}),
    .wdata(mem_rd_data),
    .raddr({cpu_index, cpu_word}),
    .rdata(ram_rdata)
  );

  // State register; reset leaves every line invalid and any partial fill abandoned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      fill_cnt_q      <= '0;
      base_q          <= '0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
      hits_q          <= '0;
      misses_q        <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      fill_cnt_q      <= fill_cnt_d;
      base_q          <= base_d;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
      hits_q          <= hits_d;
      misses_q        <= misses_d;
      tag_q           <= tag_d;
    end
  end

  // Lookup in IDLE, in-order line fill in FILL; a flush during a fill keeps that line invalid.
  always_comb begin
    state_d         = state_q;
    fill_cnt_d      = fill_cnt_q;
    base_d          = base_q;
    flush_pending_d = flush_pending_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    hits_d          = hits_q;
    misses_d        = misses_q;
    cpu_waitrequest = 1'b0;
    cpu_rd_data     = '0;
    mem_rd          = 1'b0;
    mem_addr        = '0;
    ram_we          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_rd) begin
          if (hit) begin
            cpu_rd_data = ram_rdata;
            hits_d      = hits_q + 32'd1;
          end else begin
            cpu_waitrequest = 1'b1;
            misses_d        = misses_q + 32'd1;
            state_d         = FILL;
            fill_cnt_d      = '0;
            base_d          = line_base(cpu_addr, LINE_WORDS);
          end
        end
        if (flush) begin
          valid_d = '0;
        end
      end
      FILL: begin
        cpu_waitrequest = 1'b1;
        mem_rd          = 1'b1;
        mem_addr        = base_q + 32'({fill_cnt_q, 2'b00});
        if (flush) begin
          valid_d         = '0;
          flush_pending_d = 1'b1;
        end
        if (!mem_waitrequest) begin
          ram_we     = 1'b1;
          fill_cnt_d = fill_cnt_q + WORD_W'(1);
          if (fill_cnt_q == WORD_W'(LINE_WORDS - 1)) begin
            tag_d[fill_index] = fill_tag;
            if (!flush_pending_q && !flush) begin
              valid_d[fill_index] = 1'b1;
            end
            flush_pending_d = 1'b0;
            fill_cnt_d      = '0;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench: vector table, corner sequences, random fetches vs model
module tb_icache_direct;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic [31:0] cpu_rd_data;
  logic        cpu_waitrequest;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rd_data;
  logic        mem_waitrequest = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  icache_direct #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpu_addr       (cpu_addr),
    .cpu_rd         (cpu_rd),
    .cpu_rd_data    (cpu_rd_data),
    .cpu_waitrequest(cpu_waitrequest),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_rd_data    (mem_rd_data),
    .mem_waitrequest(mem_waitrequest),
    .flush          (flush),
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
  );

  always #5 clock = ~clock;

  // Backing memory content is a fixed hash of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign mem_rd_data = memfn(mem_addr);

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Memory stall generator: 0 = never, 1 = three stall cycles per word, 2 = random.
  int wait_mode = 0;
  int wcnt = 0;
  int inj = 0;
  always @(posedge clock) begin
    #1;
    if (!mem_rd) begin
      mem_waitrequest = 1'b0;
      wcnt = 0;
    end else begin
      case (wait_mode)
        1: begin
          if (wcnt < 3) begin
            mem_waitrequest = 1'b1;
            wcnt++;
          end else begin
            mem_waitrequest = 1'b0;
            wcnt = 0;
          end
        end
        2: mem_waitrequest = ($urandom_range(0, 2) == 0);
        default: mem_waitrequest = 1'b0;
      endcase
      if (mem_waitrequest) inj++;
    end
  end

  // Record accepted memory beats and watch that a stalled request holds its address.
  logic [31:0] acc_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clock) begin
    if (prev_stall && mem_rd) chk("mem_addr_stable", mem_addr, prev_addr);
    if (mem_rd && !mem_waitrequest) acc_q.push_back(mem_addr);
    prev_stall = mem_rd && mem_waitrequest;
    prev_addr  = mem_addr;
  end

  // Reference model: which line holds which tag, plus the expected counters.
  bit          mvalid [NL];
  int          mtag [NL];
  logic [31:0] mhits = 0;
  logic [31:0] mmisses = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % NL);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'(a / (4 * LW * NL));
  endfunction

  task automatic model_flush();
    for (int j = 0; j < NL; j++) mvalid[j] = 1'b0;
  endtask

  // Hold a fetch until served; called just after a rising edge.
  task automatic fetch(input logic [31:0] a, output int stall, output logic [31:0] d,
                       output bit to);
    cpu_addr = a;
    cpu_rd = 1'b1;
    stall = 0;
    to = 1'b1;
    d = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (!cpu_waitrequest) begin
        d = cpu_rd_data;
        to = 1'b0;
        @(posedge clock);
        #1;
        break;
      end
      stall++;
      @(posedge clock);
      #1;
    end
  endtask

  // Fetch and check stall count, data, memory beats and counters; negative expectations
  // are derived from the model (a miss costs LINE_WORDS+1 plus injected memory stalls).
  task automatic do_fetch(input string nm, input logic [31:0] a, input int exp_stall,
                          input int exp_fills);
    int          stall, i, t, a0, inj0, e_stall, e_fills;
    logic [31:0] d, base;
    bit          to, hit;
    i = idx_of(a);
    t = tag_of(a);
    hit = mvalid[i] && (mtag[i] == t);
    a0 = acc_q.size();
    inj0 = inj;
    fetch(a, stall, d, to);
    if (to) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout actual=still_stalled expected=served", nm);
      return;
    end
    e_fills = (exp_fills < 0) ? (hit ? 0 : 1) : exp_fills;
    e_stall = (exp_stall < 0) ? (hit ? 0 : LW + 1 + (inj - inj0)) : exp_stall;
    base = a & ~32'(4 * LW - 1);
    chk({nm, "_stall"}, 32'(stall), 32'(e_stall));
    chk({nm, "_data"}, d, memfn(a));
    chk({nm, "_beats"}, 32'(acc_q.size() - a0), 32'(e_fills * LW));
    for (int k = 0; k < e_fills * LW; k++) begin
      if (a0 + k < acc_q.size()) chk({nm, "_beat_addr"}, acc_q[a0 + k], base + 32'(4 * (k % LW)));
    end
    if (e_fills > 0) begin
      mmisses += 32'(e_fills);
      mvalid[i] = 1'b1;
      mtag[i] = t;
    end
    mhits += 1;
    chk({nm, "_hits"}, stat_hits, mhits);
    chk({nm, "_misses"}, stat_misses, mmisses);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          wmode;
    int          exp_stall;
    int          exp_fills;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int          st;
    logic [31:0] d;
    bit          to;
    logic [31:0] a;

    // The serving cycle after a fill is itself a hit, so every miss also adds one hit.
    tbl[0] = '{32'h0000_0000, 0, 5, 1, 1, 1};
    tbl[1] = '{32'h0000_0004, 0, 0, 0, 2, 1};
    tbl[2] = '{32'h0000_0008, 0, 0, 0, 3, 1};
    tbl[3] = '{32'h0000_000C, 0, 0, 0, 4, 1};
    tbl[4] = '{32'h0000_0400, 0, 5, 1, 5, 2};
    tbl[5] = '{32'h0000_0000, 0, 5, 1, 6, 3};
    tbl[6] = '{32'h0000_0400, 0, 5, 1, 7, 4};
    tbl[7] = '{32'h0000_1010, 1, 17, 1, 8, 5};
    tbl[8] = '{32'h0000_101C, 0, 0, 0, 9, 5};
    tbl[9] = '{32'h0000_0003, 0, 5, 1, 10, 6};

    model_flush();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_waitrequest", {31'b0, cpu_waitrequest}, 32'd0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rd_data", cpu_rd_data, 32'd0);
    chk("rst_hits", stat_hits, 32'd0);
    chk("rst_misses", stat_misses, 32'd0);

    foreach (tbl[v]) begin
      wait_mode = tbl[v].wmode;
      do_fetch($sformatf("vec%0d", v), tbl[v].addr, tbl[v].exp_stall, tbl[v].exp_fills);
      chk($sformatf("vec%0d_tbl_hits", v), stat_hits, tbl[v].exp_hits);
      chk($sformatf("vec%0d_tbl_misses", v), stat_misses, tbl[v].exp_misses);
    end
    wait_mode = 0;

    // Flush in IDLE together with a hit: the hit is still served.
    cpu_addr = 32'h0000_0008;
    cpu_rd = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_idle_wait", {31'b0, cpu_waitrequest}, 32'd0);
    chk("flush_idle_data", cpu_rd_data, memfn(32'h8));
    @(posedge clock);
    #1;
    flush = 1'b0;
    cpu_rd = 1'b0;
    mhits += 1;
    model_flush();
    chk("flush_idle_hits", stat_hits, mhits);
    do_fetch("after_flush", 32'h0000_0008, 5, 1);
    do_fetch("line10", 32'h0000_0010, 5, 1);

    // Flush mid-fill: fill completes unvalidated, then a second full refill.
    fork
      do_fetch("flush_fill", 32'h0000_0100, 2 * (LW + 1), 2);
      begin
        repeat (2) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
      end
    join
    model_flush();
    mvalid[idx_of(32'h100)] = 1'b1;
    do_fetch("stale0", 32'h0000_0000, 5, 1);
    do_fetch("stale10", 32'h0000_0014, 5, 1);
    do_fetch("kept100", 32'h0000_0104, 0, 0);

    // Reset in the middle of a stalled fill.
    wait_mode = 1;
    cpu_addr = 32'h0000_2000;
    cpu_rd = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_fill_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_fill_hits", stat_hits, 32'd0);
    chk("rst_fill_misses", stat_misses, 32'd0);
    cpu_rd = 1'b0;
    #1;
    chk("rst_fill_wait", {31'b0, cpu_waitrequest}, 32'd0);
    chk("rst_fill_addr", mem_addr, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_mode = 0;
    mhits = 0;
    mmisses = 0;
    model_flush();
    @(posedge clock);
    #1;
    do_fetch("post_rst", 32'h0000_2000, 5, 1);
    do_fetch("post_rst_old", 32'h0000_0104, 5, 1);

    // Random fetches over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      wait_mode = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, LW - 1)) << 2) | 32'($urandom_range(0, 3));
      do_fetch("rnd", a, -1, -1);
    end
    cpu_rd = 1'b0;
    wait_mode = 0;
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
